program_loader: RTL and testbench

//  Byte-stream boot loader: the write side of program memory.

---
 rtl/program_loader_if.sv | 23 ++
 rtl/program_loader.sv | 156 +++++++++++++++
 tb/tb_program_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream input link and program-RAM write/status bundle of the boot loader.
// A byte moves on a rising edge where i_valid and o_ready are both 1; while o_ready is 0 the source holds i_byte and i_valid unchanged.
interface program_loader_if;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        o_ready;
    logic        o_we;
    logic [0:15] o_waddr;
    logic [0:17] o_wdata;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_err;

    modport slave (
        input  i_byte, i_valid,
        output o_ready, o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_err
    );

    modport master (
        output i_byte, i_valid,
        input  o_ready, o_we, o_waddr, o_wdata, o_cpu_hold, o_done, o_err
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: turns a framed byte stream into sequential 18-bit program RAM writes.
// The CPU stays held until the whole frame has arrived and its XOR checksum matches.
module program_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter logic [16:0] MAX_WORDS = 17'd65536
) (
    input  logic               i_clk,
    input  logic               i_rst,
    program_loader_if.slave    bus,
    output logic [3:0]         dbg_state
);

    typedef enum logic [3:0] {
        S_LEN_HI = 4'd0,
        S_LEN_LO = 4'd1,
        S_B0     = 4'd2,
        S_B1     = 4'd3,
        S_B2     = 4'd4,
        S_WRITE  = 4'd5,
        S_CSUM   = 4'd6,
        S_DONE   = 4'd7,
        S_ERR    = 4'd8
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] n_words;
    logic [16:0] idx;
    logic [1:0]  b0_bits;
    logic [7:0]  b1_byte;
    logic [7:0]  csum;
    logic [15:0] waddr;
    logic [17:0] wdata;
    logic        ready_state;
    logic        xfer;
    logic [15:0] hdr_count;

    // Readiness depends on state only, so the handshake has no combinational path from i_valid.
    always_comb begin
        ready_state = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2, S_CSUM: ready_state = 1'b1;
            default:                                      ready_state = 1'b0;
        endcase
    end

    assign xfer      = bus.i_valid & ready_state & ~i_rst;
    assign hdr_count = {len_hi, bus.i_byte};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_LEN_HI;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LEN_HI: begin
                if (xfer) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) begin
                    if ({1'b0, hdr_count} > MAX_WORDS) begin
                        state_nxt = S_ERR;
                    end else if (hdr_count == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_B0;
                    end
                end
            end
            S_B0: begin
                if (xfer) state_nxt = S_B1;
            end
            S_B1: begin
                if (xfer) state_nxt = S_B2;
            end
            S_B2: begin
                if (xfer) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                // idx still holds the index of the word being written this cycle.
                if (idx + 17'd1 == {1'b0, n_words}) begin
                    state_nxt = S_CSUM;
                end else begin
                    state_nxt = S_B0;
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    if (bus.i_byte == csum) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_hi  <= 8'h00;
            n_words <= 16'h0000;
            idx     <= 17'd0;
            b0_bits <= 2'b00;
            b1_byte <= 8'h00;
            csum    <= 8'h00;
            waddr   <= BASE_ADDR;
            wdata   <= 18'h00000;
        end else begin
            if (xfer) begin
                case (state)
                    S_LEN_HI: len_hi <= bus.i_byte;
                    S_LEN_LO: n_words <= hdr_count;
                    S_B0: begin
                        b0_bits <= bus.i_byte[1:0];
                        csum    <= csum ^ bus.i_byte;
                    end
                    S_B1: begin
                        b1_byte <= bus.i_byte;
                        csum    <= csum ^ bus.i_byte;
                    end
                    S_B2: begin
                        // Address and word are registered here so they are stable for the whole strobe cycle.
                        csum  <= csum ^ bus.i_byte;
                        waddr <= BASE_ADDR + idx[15:0];
                        wdata <= {b0_bits, b1_byte, bus.i_byte};
                    end
                    default: ;
                endcase
            end
            if (state == S_WRITE) begin
                idx <= idx + 17'd1;
            end
        end
    end

    // Outputs are masked by reset so the reset cycle itself shows the idle/held values.
    assign bus.o_ready    = ready_state & ~i_rst;
    assign bus.o_we       = (state == S_WRITE) & ~i_rst;
    assign bus.o_waddr    = waddr;
    assign bus.o_wdata    = wdata;
    assign bus.o_done     = (state == S_DONE) & ~i_rst;
    assign bus.o_err      = (state == S_ERR) & ~i_rst;
    assign bus.o_cpu_hold = ~((state == S_DONE) & ~i_rst);
    assign dbg_state      = state;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: default, MAX_WORDS=4 and BASE_ADDR=FFFF instances.
// Expected RAM writes are queued per instance and popped by a monitor on each strobe.
module tb_program_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    program_loader_if if0 ();
    program_loader_if if1 ();
    program_loader_if if2 ();
    logic [3:0] dbg0, dbg1, dbg2;

    program_loader u0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave), .dbg_state(dbg0));
    program_loader #(.MAX_WORDS(17'd4)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave), .dbg_state(dbg1));
    program_loader #(.BASE_ADDR(16'hFFFF)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave), .dbg_state(dbg2));

    int total = 0;
    int bad   = 0;
    logic [33:0] exp_q0[$];
    logic [33:0] exp_q1[$];
    logic [33:0] exp_q2[$];
    logic [7:0]  frame[$];

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=event expected=none", tag);
    endtask

    // ---------------- write monitors (negedge, away from the active edge) ----------------
    always @(negedge clk) begin
        if (if0.o_we === 1'b1) begin
            chk("dut0_ready_in_write", 34'(if0.o_ready), 34'd0);
            if (exp_q0.size() == 0) fail_now("dut0_unexpected_write");
            else chk("dut0_write", {if0.o_waddr, if0.o_wdata}, exp_q0.pop_front());
        end
        if (if1.o_we === 1'b1) begin
            if (exp_q1.size() == 0) fail_now("dut1_unexpected_write");
            else chk("dut1_write", {if1.o_waddr, if1.o_wdata}, exp_q1.pop_front());
        end
        if (if2.o_we === 1'b1) begin
            chk("dut2_ready_in_write", 34'(if2.o_ready), 34'd0);
            if (exp_q2.size() == 0) fail_now("dut2_unexpected_write");
            else chk("dut2_write", {if2.o_waddr, if2.o_wdata}, exp_q2.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input int sel, input logic v, input logic [7:0] b);
        case (sel)
            0: begin if0.i_valid = v; if0.i_byte = b; end
            1: begin if1.i_valid = v; if1.i_byte = b; end
            default: begin if2.i_valid = v; if2.i_byte = b; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel)
            0:       return if0.o_ready;
            1:       return if1.o_ready;
            default: return if2.o_ready;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the byte was taken.
    task automatic send(input int sel, input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        set_in(sel, 1'b1, b);
        n = 0;
        while (get_ready(sel) !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) fail_now("send_timeout");
        @(negedge clk);
        set_in(sel, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int sel, input bit gaps);
        foreach (frame[i]) send(sel, frame[i], gaps);
    endtask

    task automatic do_reset();
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", 34'(if0.o_ready), 34'd0);
        chk("rst_hold", 34'(if0.o_cpu_hold), 34'd1);
        chk("rst_done_err", 34'({if0.o_done, if0.o_err}), 34'd0);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_t1();
        exp_q0.push_back({16'h0000, 18'h0000E});
        exp_q0.push_back({16'h0001, 18'h32800});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        set_in(0, 1'b0, 8'h00);
        set_in(1, 1'b0, 8'h00);
        set_in(2, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("reset_ready", 34'(if0.o_ready), 34'd0);
        chk("reset_we", 34'(if0.o_we), 34'd0);
        chk("reset_waddr", 34'(if0.o_waddr), 34'h0000);
        chk("reset_wdata", 34'(if0.o_wdata), 34'h00000);
        chk("reset_hold_done_err", 34'({if0.o_cpu_hold, if0.o_done, if0.o_err}), 34'b100);
        chk("reset_waddr_base_ffff", 34'(if2.o_waddr), 34'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 34'(if0.o_ready), 34'd1);

        // Test 1: two words, good checksum 0x25.
        push_t1();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h0E, 8'h03, 8'h28, 8'h00, 8'h25};
        send_frame(0, 1'b0);
        chk("t1_done_err_hold", 34'({if0.o_done, if0.o_err, if0.o_cpu_hold}), 34'b100);
        chk("t1_ready_done", 34'(if0.o_ready), 34'd0);
        chk("t1_drained", 34'(exp_q0.size()), 34'd0);
        chk("t1_last_addr_held", 34'(if0.o_waddr), 34'h0001);
        chk("t1_last_data_held", 34'(if0.o_wdata), 34'h32800);
        set_in(0, 1'b1, 8'hAA);
        repeat (3) @(negedge clk);
        chk("t1_done_sticky", 34'({if0.o_done, if0.o_cpu_hold}), 34'b10);
        do_reset();

        // Test 2: bad checksum 0x24; writes still happen.
        push_t1();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h0E, 8'h03, 8'h28, 8'h00, 8'h24};
        send_frame(0, 1'b0);
        chk("t2_done_err_hold", 34'({if0.o_done, if0.o_err, if0.o_cpu_hold}), 34'b011);
        chk("t2_drained", 34'(exp_q0.size()), 34'd0);
        repeat (2) @(negedge clk);
        chk("t2_err_sticky", 34'({if0.o_err, if0.o_ready}), 34'b10);
        do_reset();

        // Test 3: empty frame.
        frame = '{8'h00, 8'h00, 8'h00};
        send_frame(0, 1'b0);
        chk("t3_done_err_hold", 34'({if0.o_done, if0.o_err, if0.o_cpu_hold}), 34'b100);
        do_reset();

        // Test 4: test-1 frame with random idle gaps on i_valid.
        push_t1();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h0E, 8'h03, 8'h28, 8'h00, 8'h25};
        send_frame(0, 1'b1);
        chk("t4_done_err_hold", 34'({if0.o_done, if0.o_err, if0.o_cpu_hold}), 34'b100);
        chk("t4_drained", 34'(exp_q0.size()), 34'd0);
        do_reset();

        // Test 5: reset after B1 of word 1, then the full frame.
        exp_q0.push_back({16'h0000, 18'h0000E});
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h0E, 8'h03, 8'h28};
        send_frame(0, 1'b0);
        do_reset();
        chk("t5_abort_drained", 34'(exp_q0.size()), 34'd0);
        chk("t5_abort_no_done", 34'({if0.o_done, if0.o_err}), 34'd0);
        push_t1();
        frame = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h0E, 8'h03, 8'h28, 8'h00, 8'h25};
        send_frame(0, 1'b0);
        chk("t5_done_err_hold", 34'({if0.o_done, if0.o_err, if0.o_cpu_hold}), 34'b100);
        chk("t5_drained", 34'(exp_q0.size()), 34'd0);

        // Test 6a: MAX_WORDS=4, header count 5.
        frame = '{8'h00, 8'h05};
        send_frame(1, 1'b0);
        chk("t6a_done_err_hold", 34'({if1.o_done, if1.o_err, if1.o_cpu_hold}), 34'b011);
        chk("t6a_ready", 34'(if1.o_ready), 34'd0);

        // Test 6b: BASE_ADDR=FFFF wraps to 0000; B0=FF gives instr[0:1]=11, csum FF^01^02=FC.
        exp_q2.push_back({16'hFFFF, 18'h30001});
        exp_q2.push_back({16'h0000, 18'h00002});
        frame = '{8'h00, 8'h02, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'hFC};
        send_frame(2, 1'b0);
        chk("t6b_done_err_hold", 34'({if2.o_done, if2.o_err, if2.o_cpu_hold}), 34'b100);
        chk("t6b_last_addr", 34'(if2.o_waddr), 34'h0000);

        repeat (4) @(negedge clk);
        chk("final_q0_empty", 34'(exp_q0.size()), 34'd0);
        chk("final_q1_empty", 34'(exp_q1.size()), 34'd0);
        chk("final_q2_empty", 34'(exp_q2.size()), 34'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
